// File: rtl/axis_msg_upsizer.sv
// axis_msg_upsizer
// Packs a narrow AXI-Stream message into wide, block-aligned beats for the
// SHA-2 padder. It also delivers the running message byte count with every
// output block.
// Storage is an assembly register plus an output register, so input keeps
// flowing while the output is back-pressured.
//
// Ports:
//   axi_aclk, axi_reset      clock, synchronous active-high reset
//   s_axis_*                 narrow input stream; byte 0 is in the top byte
//                            lane; tuser is sampled on a message's first beat
//   m_axis_*                 wide output stream; lane 0 is in the top lane
//   m_axis_tuser             {first-beat s_axis_tuser, cumulative byte count}
//   err_tkeep                sticky flag for illegal tkeep patterns
module axis_msg_upsizer #(
   parameter int S_AXIS_DATA_WIDTH  = 64,
   parameter int M_AXIS_DATA_WIDTH  = 512,
   parameter int S_AXIS_TUSER_WIDTH = 64,
   parameter int M_AXIS_TUSER_WIDTH = 128,
   parameter int LEN_WIDTH          = 64
) (
   input  logic                            axi_aclk,
   input  logic                            axi_reset,
   input  logic [S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
   input  logic [S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
   input  logic [S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
   input  logic                            s_axis_tvalid,
   output logic                            s_axis_tready,
   input  logic                            s_axis_tlast,
   output logic [M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
   output logic [M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
   output logic [M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
   output logic                            m_axis_tvalid,
   input  logic                            m_axis_tready,
   output logic                            m_axis_tlast,
   output logic                            err_tkeep
);

   localparam int RATIO  = M_AXIS_DATA_WIDTH / S_AXIS_DATA_WIDTH;
   localparam int LANE_W = $clog2(RATIO);
   localparam int SK     = S_AXIS_DATA_WIDTH / 8;
   localparam int MK     = M_AXIS_DATA_WIDTH / 8;

   // Number of valid bytes in one input beat.
   function automatic logic [LEN_WIDTH-1:0] keep_popcount(input logic [SK-1:0] keep);
      logic [LEN_WIDTH-1:0] n;
      n = '0;
      for (int i = 0; i < SK; i++) begin
         n = n + LEN_WIDTH'(keep[i]);
      end
      return n;
   endfunction

   // The keep pattern must be 1..10..0, filled from the top byte down.
   // Its inverse is then 0..01..1, so adding one to the inverse carries
   // cleanly out of every set bit and leaves no overlap.
   function automatic logic keep_contiguous(input logic [SK-1:0] keep);
      logic [SK-1:0] inv;
      inv = ~keep;
      return ((inv & (inv + SK'(1))) == '0);
   endfunction

   logic [LANE_W-1:0]             lane_r;
   logic [LEN_WIDTH-1:0]          cnt_r;
   logic [S_AXIS_TUSER_WIDTH-1:0] user_r;
   logic                          msg_start_r;
   logic [M_AXIS_DATA_WIDTH-1:0]  asm_data_r;
   logic [MK-1:0]                 asm_keep_r;
   logic                          asm_last_r;
   logic [LEN_WIDTH-1:0]          asm_cnt_r;
   logic [S_AXIS_TUSER_WIDTH-1:0] asm_user_r;
   logic                          blk_done_r;
   logic [M_AXIS_DATA_WIDTH-1:0]  out_data_r;
   logic [MK-1:0]                 out_keep_r;
   logic [M_AXIS_TUSER_WIDTH-1:0] out_user_r;
   logic                          out_last_r;
   logic                          out_valid_r;
   logic                          err_r;

   logic                          tready_s;
   logic                          accept_s;
   logic                          complete_s;
   logic                          xfer_s;
   logic                          keep_bad_s;
   logic [LEN_WIDTH-1:0]          cnt_nx_s;
   logic [S_AXIS_TUSER_WIDTH-1:0] user_cur_s;
   logic [M_AXIS_DATA_WIDTH-1:0]  asm_data_nx_s;
   logic [MK-1:0]                 asm_keep_nx_s;
   logic [M_AXIS_TUSER_WIDTH-1:0] tuser_s;

   // Handshake decode, lane packing and the output sideband layout.
   always_comb begin
      tready_s   = !axi_reset && (!blk_done_r || !out_valid_r || m_axis_tready);
      accept_s   = s_axis_tvalid && tready_s;
      complete_s = accept_s && ((lane_r == LANE_W'(RATIO - 1)) || s_axis_tlast);
      xfer_s     = blk_done_r && (!out_valid_r || m_axis_tready);
      keep_bad_s = s_axis_tlast ? !keep_contiguous(s_axis_tkeep)
                                : (s_axis_tkeep != {SK{1'b1}});
      cnt_nx_s   = cnt_r + keep_popcount(s_axis_tkeep);
      user_cur_s = msg_start_r ? s_axis_tuser : user_r;
      // Lane 0 starts a fresh block, so the lanes above it are zero.
      // This also keeps a short final block zero-filled.
      asm_data_nx_s = (lane_r == LANE_W'(0)) ? '0 : asm_data_r;
      asm_keep_nx_s = (lane_r == LANE_W'(0)) ? '0 : asm_keep_r;
      asm_data_nx_s[(M_AXIS_DATA_WIDTH - 1) - int'(lane_r) * S_AXIS_DATA_WIDTH -: S_AXIS_DATA_WIDTH]
         = s_axis_tdata;
      asm_keep_nx_s[(MK - 1) - int'(lane_r) * SK -: SK] = s_axis_tkeep;
      tuser_s = '0;
      tuser_s[LEN_WIDTH-1:0] = asm_cnt_r;
      tuser_s[LEN_WIDTH +: S_AXIS_TUSER_WIDTH] = asm_user_r;
   end

   // Assembly, message tracking and the output register.
   always_ff @(posedge axi_aclk) begin
      if (axi_reset) begin
         lane_r      <= '0;
         cnt_r       <= '0;
         user_r      <= '0;
         msg_start_r <= 1'b1;
         asm_data_r  <= '0;
         asm_keep_r  <= '0;
         asm_last_r  <= 1'b0;
         asm_cnt_r   <= '0;
         asm_user_r  <= '0;
         blk_done_r  <= 1'b0;
         out_data_r  <= '0;
         out_keep_r  <= '0;
         out_user_r  <= '0;
         out_last_r  <= 1'b0;
         out_valid_r <= 1'b0;
         err_r       <= 1'b0;
      end else begin
         if (accept_s) begin
            asm_data_r <= asm_data_nx_s;
            asm_keep_r <= asm_keep_nx_s;
            lane_r     <= complete_s ? LANE_W'(0) : lane_r + LANE_W'(1);
            if (s_axis_tlast) begin
               cnt_r       <= '0;
               user_r      <= '0;
               msg_start_r <= 1'b1;
            end else begin
               cnt_r       <= cnt_nx_s;
               user_r      <= user_cur_s;
               msg_start_r <= 1'b0;
            end
            if (keep_bad_s) begin
               err_r <= 1'b1;
            end else begin
               err_r <= err_r;
            end
            if (complete_s) begin
               asm_last_r <= s_axis_tlast;
               asm_cnt_r  <= cnt_nx_s;
               asm_user_r <= user_cur_s;
            end else begin
               asm_last_r <= asm_last_r;
            end
         end else begin
            lane_r <= lane_r;
         end
         // A block completing on the same edge as a transfer stays pending.
         blk_done_r <= complete_s ? 1'b1 : (xfer_s ? 1'b0 : blk_done_r);
         if (xfer_s) begin
            out_data_r  <= asm_data_r;
            out_keep_r  <= asm_keep_r;
            out_user_r  <= tuser_s;
            out_last_r  <= asm_last_r;
            out_valid_r <= 1'b1;
         end else if (m_axis_tready) begin
            out_valid_r <= 1'b0;
         end else begin
            out_valid_r <= out_valid_r;
         end
      end
   end

   assign s_axis_tready = tready_s;
   assign m_axis_tdata  = out_data_r;
   assign m_axis_tkeep  = out_keep_r;
   assign m_axis_tuser  = out_user_r;
   assign m_axis_tlast  = out_last_r;
   assign m_axis_tvalid = out_valid_r;
   assign err_tkeep     = err_r;

endmodule
